// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl
//   Sequencer for the program-2 message decryption. On a falling edge of req
//   it reads the 64 encrypted bytes at DM[64..127], recovers the LFSR seed
//   from the space-padded preamble, finds the first of 9 tap patterns whose
//   keystream reproduces the preamble, then writes the 64 decrypted bytes to
//   DM[0..63] and raises ack.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   - bit 7 of each encrypted byte is an even-parity bit over
//                 bits 6:0; bad bytes decode to 0x80, fail preamble compares
//                 and set the sticky parity_err flag.
//     undefined - bit 7 is ignored and parity_err is tied low.
//
//   Ports
//     clk          in   system clock, rising edge
//     init         in   asynchronous active-high reset
//     req          in   start request (run launched on its falling edge)
//     ack          out  run complete, held until req rises
//     mem_addr     out  DM address (read data returns combinationally)
//     mem_rd_data  in   DM read data
//     mem_wr_en    out  DM write strobe
//     mem_wr_data  out  DM write data
//     pat_idx      out  matched tap pattern index, 0xF when none matched
//     match_fail   out  no tap pattern fit the preamble
//     parity_err   out  sticky parity mismatch flag
module lfsr_decrypt_ctrl #(
    parameter int unsigned PRE_CHK = 9
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic [6:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [3:0] pat_idx,
    output logic       match_fail,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_TRY,
        S_DRD,
        S_DWR,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_CHK = 6'(PRE_CHK);

    function automatic logic [6:0] tap_rom(input logic [3:0] k);
        logic [6:0] t;
        case (k)
            4'd0:    t = 7'h60;
            4'd1:    t = 7'h48;
            4'd2:    t = 7'h78;
            4'd3:    t = 7'h72;
            4'd4:    t = 7'h6A;
            4'd5:    t = 7'h69;
            4'd6:    t = 7'h5C;
            4'd7:    t = 7'h7E;
            4'd8:    t = 7'h7B;
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    state_t     state_q, state_d;
    logic       req_q;
    logic [3:0] k_q, k_d;
    logic [5:0] i_q, i_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] seed_q, seed_d;
    logic [7:0] d_q, d_d;
    logic [3:0] pat_q, pat_d;
    logic       fail_q, fail_d;
    logic       par_ok;
    logic       hit;

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;
    assign par_ok     = (mem_rd_data[7] == ^mem_rd_data[6:0]);
    assign parity_err = perr_q;
`else
    logic rd_par_unused;
    assign rd_par_unused = mem_rd_data[7];
    assign par_ok        = 1'b1;
    assign parity_err    = 1'b0;
`endif

    assign pat_idx    = pat_q;
    assign match_fail = fail_q;
    assign hit        = ((mem_rd_data[6:0] ^ lfsr_q) == 7'h20) && par_ok;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        i_d         = i_q;
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        d_d         = d_q;
        pat_d       = pat_q;
        fail_d      = fail_q;
`ifdef PARITY_CHECK_EN
        perr_d      = perr_q;
`endif
        ack         = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (req_q && !req) begin
                    fail_d  = 1'b0;
`ifdef PARITY_CHECK_EN
                    perr_d  = 1'b0;
`endif
                    k_d     = '0;
                    state_d = S_SEED;
                end
            end

            S_SEED: begin
                mem_addr = 7'd64;
                seed_d   = mem_rd_data[6:0] ^ 7'h20;
                lfsr_d   = lfsr_step(seed_d, tap_rom(k_q));
                i_d      = 6'd1;
                state_d  = S_TRY;
            end

            S_TRY: begin
                mem_addr = {1'b1, i_q};
                if (hit) begin
                    if (i_q == LAST_CHK) begin
                        pat_d   = k_q;
                        lfsr_d  = seed_q;
                        i_d     = '0;
                        state_d = S_DRD;
                    end else begin
                        i_d    = i_q + 6'd1;
                        lfsr_d = lfsr_step(lfsr_q, tap_rom(k_q));
                    end
                end else if (k_q != 4'd8) begin
                    // Move straight to the next candidate: its first keystream
                    // byte is produced here so the next compare starts at i=1.
                    k_d    = k_q + 4'd1;
                    i_d    = 6'd1;
                    lfsr_d = lfsr_step(seed_q, tap_rom(k_q + 4'd1));
                end else begin
                    fail_d  = 1'b1;
                    pat_d   = 4'hF;
                    state_d = S_DONE;
                end
            end

            S_DRD: begin
                mem_addr = {1'b1, i_q};
                d_d      = {1'b0, mem_rd_data[6:0] ^ lfsr_q};
`ifdef PARITY_CHECK_EN
                if (!par_ok) begin
                    d_d    = 8'h80;
                    perr_d = 1'b1;
                end
`endif
                state_d = S_DWR;
            end

            S_DWR: begin
                mem_addr    = {1'b0, i_q};
                mem_wr_en   = 1'b1;
                mem_wr_data = d_q;
                lfsr_d      = lfsr_step(lfsr_q, tap_rom(k_q));
                if (i_q == 6'd63) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 6'd1;
                    state_d = S_DRD;
                end
            end

            S_DONE: begin
                ack = 1'b1;
                if (req) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            k_q     <= '0;
            i_q     <= '0;
            lfsr_q  <= '0;
            seed_q  <= '0;
            d_q     <= '0;
            pat_q   <= '0;
            fail_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req;
            k_q     <= k_d;
            i_q     <= i_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            d_q     <= d_d;
            pat_q   <= pat_d;
            fail_q  <= fail_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Testbench for lfsr_decrypt_ctrl: behavioural DM model plus a reference
// decryptor that searches the tap patterns over whole keystream arrays.
module tb_lfsr_decrypt_ctrl;

    localparam int unsigned PRE_CHK = 9;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                        7'h69, 7'h5C, 7'h7E, 7'h7B};

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic [6:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [3:0] pat_idx;
    logic       match_fail;
    logic       parity_err;

    logic [7:0] dm     [128];
    logic [7:0] pt     [64];
    logic [7:0] ct     [64];
    logic [7:0] exp_dm [64];
    logic [7:0] pre_dm [64];

    int n_checks = 0;
    int n_errors = 0;
    int pat_m;
    int cmps_m;
    bit perr_m;

    always #5 clk = ~clk;

    assign mem_rd_data = dm[mem_addr];

    lfsr_decrypt_ctrl #(.PRE_CHK(PRE_CHK)) dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .pat_idx     (pat_idx),
        .match_fail  (match_fail),
        .parity_err  (parity_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Next keystream value: shift left, feedback is the parity of tapped bits.
    function automatic logic [6:0] nxt(input logic [6:0] s, input int k);
        logic [6:0] r;
        r    = s << 1;
        r[0] = 1'($countones(s & TAPS[k]) % 2);
        return r;
    endfunction

    function automatic bit bad(input logic [7:0] b);
        return PAR && (b[7] != ^b[6:0]);
    endfunction

    task automatic make_plain(input int pre);
        for (int j = 0; j < 64; j++)
            pt[j] = (j < pre) ? 8'h20 : 8'($urandom_range(8'h21, 8'h7E));
    endtask

    task automatic encrypt(input logic [6:0] seed, input int k);
        logic [6:0] ks;
        logic [6:0] c;
        ks = seed;
        for (int j = 0; j < 64; j++) begin
            c         = pt[j][6:0] ^ ks;
            ct[j]     = {^c, c};
            dm[64+j]  = ct[j];
            ks        = nxt(ks, k);
        end
    endtask

    // Reference: try each pattern in order on the preamble, decode with the
    // first one that fits; count compares for the latency prediction.
    task automatic model_run();
        logic [6:0] seed;
        logic [6:0] ks;
        bit         ok;
        seed   = ct[0][6:0] ^ 7'h20;
        pat_m  = -1;
        cmps_m = 0;
        perr_m = 1'b0;
        for (int k = 0; k < 9 && pat_m < 0; k++) begin
            ks = seed;
            ok = 1'b1;
            for (int j = 1; j <= int'(PRE_CHK) && ok; j++) begin
                ks = nxt(ks, k);
                cmps_m++;
                if (((ct[j][6:0] ^ ks) != 7'h20) || bad(ct[j])) ok = 1'b0;
            end
            if (ok) pat_m = k;
        end
        if (pat_m >= 0) begin
            ks = seed;
            for (int j = 0; j < 64; j++) begin
                if (bad(ct[j])) begin
                    exp_dm[j] = 8'h80;
                    perr_m    = 1'b1;
                end else begin
                    exp_dm[j] = {1'b0, ct[j][6:0] ^ ks};
                end
                ks = nxt(ks, pat_m);
            end
        end else begin
            for (int j = 0; j < 64; j++) exp_dm[j] = pre_dm[j];
        end
    endtask

    task automatic kick();
        @(negedge clk) req = 1'b1;
        @(negedge clk);
        @(negedge clk) req = 1'b0;
    endtask

    // Launch a run and wait for ack; lat = edges from SEED entry to ack.
    task automatic run(output int lat);
        lat = -1;
        kick();
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (mem_wr_en) dm[mem_addr] = mem_wr_data;
            if (ack) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_run(input string tag, output int lat);
        int exp_lat;
        for (int j = 0; j < 64; j++) pre_dm[j] = dm[j];
        model_run();
        run(lat);
        exp_lat = (pat_m >= 0) ? cmps_m + 129 : cmps_m + 1;
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_pat"}, 32'(pat_idx), (pat_m >= 0) ? pat_m : 32'hF);
        check_eq({tag, "_fail"}, 32'(match_fail), (pat_m < 0) ? 32'd1 : 32'd0);
        check_eq({tag, "_perr"}, 32'(parity_err), 32'(perr_m));
        for (int j = 0; j < 64; j++)
            check_eq($sformatf("%s_dm%0d", tag, j), 32'(dm[j]), 32'(exp_dm[j]));
    endtask

    initial begin
        int         lat;
        int         tries;
        int         k;
        int         drops;
        logic [6:0] seed;
        bit         hit20;

        init = 1'b1;
        req  = 1'b0;
        for (int j = 0; j < 128; j++) dm[j] = '0;
        #1;
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wr_data", 32'(mem_wr_data), 32'd0);
        check_eq("rst_pat", 32'(pat_idx), 32'd0);
        check_eq("rst_fail", 32'(match_fail), 32'd0);
        check_eq("rst_perr", 32'(parity_err), 32'd0);
        repeat (3) @(negedge clk);
        init = 1'b0;

        // Seed 0x01, pattern 0, preamble 10, message "Hi"
        for (int j = 0; j < 64; j++) pt[j] = 8'h20;
        pt[10] = 8'h48;
        pt[11] = 8'h69;
        encrypt(7'h01, 0);
        check_run("p0", lat);
        check_eq("p0_lat138", lat, 32'd138);
        check_eq("p0_pat0", 32'(pat_idx), 32'd0);
        check_eq("p0_dm10", 32'(dm[10]), 32'h48);
        check_eq("p0_dm11", 32'(dm[11]), 32'h69);
        check_eq("p0_dm12", 32'(dm[12]), 32'h20);

        // Pattern 8, random nonzero seed, preamble 26
        tries = 0;
        do begin
            seed = 7'($urandom_range(1, 127));
            make_plain(26);
            encrypt(seed, 8);
            for (int j = 0; j < 64; j++) pre_dm[j] = dm[j];
            model_run();
            tries++;
        end while (pat_m != 8 && tries < 20);
        check_run("p8", lat);
        check_eq("p8_pat8", 32'(pat_idx), 32'd8);

        // No match: random stream, DM[0..63] must be untouched
        for (int j = 0; j < 64; j++) begin
            ct[j]    = 8'($urandom);
            dm[64+j] = ct[j];
            dm[j]    = 8'($urandom);
        end
        check_run("nm", lat);
        check_eq("nm_fail", 32'(match_fail), 32'd1);
        check_eq("nm_patF", 32'(pat_idx), 32'hF);
        check_eq("nm_lat_le82", 32'(lat <= 82 && lat >= 0), 32'd1);

        // Parity error on DM[100]
        k    = $urandom_range(0, 8);
        seed = 7'($urandom_range(1, 127));
        make_plain(12);
        encrypt(seed, k);
        ct[36][7] = ~ct[36][7];
        dm[100]   = ct[36];
        check_run("par", lat);
        check_eq("par_dm36", 32'(dm[36]), PAR ? 32'h80 : 32'(pt[36]));
        check_eq("par_flag", 32'(parity_err), 32'(PAR));

        // Reset during the DWR of byte 20
        k    = $urandom_range(0, 8);
        seed = 7'($urandom_range(1, 127));
        make_plain(10);
        encrypt(seed, k);
        for (int j = 0; j < 64; j++) begin
            dm[j]     = 8'hEE;
            pre_dm[j] = 8'hEE;
        end
        model_run();
        kick();
        hit20 = 1'b0;
        for (int n = 0; n < 400 && !hit20; n++) begin
            @(negedge clk);
            if (mem_wr_en && mem_addr == 7'd20) hit20 = 1'b1;
            else if (mem_wr_en) dm[mem_addr] = mem_wr_data;
        end
        check_eq("rst20_reached", 32'(hit20), 32'd1);
        init = 1'b1;
        #1;
        check_eq("rst20_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("rst20_ack", 32'(ack), 32'd0);
        check_eq("rst20_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("rst20_no_write", 32'(mem_wr_en), 32'd0);
        init = 1'b0;
        check_eq("rst20_dm19", 32'(dm[19]), 32'(exp_dm[19]));
        check_eq("rst20_dm20", 32'(dm[20]), 32'hEE);
        check_run("rerun", lat);

        // Handshake: ack holds while req stays low, drops after req rises
        drops = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ack) drops++;
        end
        check_eq("hs_hold", drops, 32'd0);
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hs_release", 32'(ack), 32'd0);
        k    = $urandom_range(0, 8);
        seed = 7'($urandom_range(1, 127));
        make_plain($urandom_range(10, 30));
        encrypt(seed, k);
        check_run("hs_second", lat);

        // Random runs
        for (int r = 0; r < 3; r++) begin
            k    = $urandom_range(0, 8);
            seed = 7'($urandom_range(1, 127));
            make_plain($urandom_range(10, 40));
            encrypt(seed, k);
            check_run($sformatf("rnd%0d", r), lat);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_decrypt_ctrl.md
# lfsr_decrypt_ctrl

Hardware sequencer for the program-2 message decryption, sitting beside the data memory (`DM`) in `top_level`. On a `req` start, it reads the 64 encrypted bytes at `DM[64..127]` and recovers the LFSR seed from the space-padded preamble. It then finds which of the 9 maximal-length tap patterns generated the stream and writes the 64 decrypted bytes to `DM[0..63]`. `ack` signals completion.

## Interface
- `PRE_CHK`, default 9: preamble bytes after byte 0 compared per candidate pattern. The preamble is always ≥10 bytes, so the legal range is 1..9.
- `clk`  in  1  system clock, rising edge.
- `init`  in  1  reset; asynchronous, active-high.
- `req`  in  1  start; a run is launched on the falling edge of `req`.
- `ack`  out  1  run complete; held until `req` rises.
- `mem_addr`  out  7  DM address; read data is combinational in the same cycle.
- `mem_rd_data`  in  8  DM read data.
- `mem_wr_en`  out  1  DM write strobe, one cycle.
- `mem_wr_data`  out  8  DM write data.
- `pat_idx`  out  4  index 0..8 of the matched tap pattern; 0xF if no pattern matched.
- `match_fail`  out  1  no candidate pattern fit the preamble.
- `parity_err`  out  1  sticky flag: a parity mismatch was seen (only with `PARITY_CHECK_EN`).

## Operation
- **Tap ROM**, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- **LFSR step**: `s' = {s[5:0], ^(s & taps)}`, all 7-bit.
- **Start detection**: `req_q` registers `req`; `req_q` resets to 0. Start is `req_q & ~req` while in `IDLE`.
- **IDLE**
  - Outputs are quiescent.
  - On start: clear `parity_err` and `match_fail`, set `k=0`, go to `SEED`.
- **SEED** (1 cycle)
  - Read address 64; `seed = rd[6:0] ^ 0x20`.
  - Set `lfsr = step(seed, taps[k])`, `i=1`, go to `TRY`.
- **TRY** (1 cycle per compare)
  - Read address 64+i and compare `rd[6:0] ^ lfsr` to 0x20.
  - Match with `i<PRE_CHK`: `i++`, step `lfsr`.
  - Match with `i==PRE_CHK`: latch `pat_idx=k`, `lfsr=seed`, `i=0`, go to `DRD`.
  - Mismatch with `k<8`: `k++`, `i=1`, `lfsr = step(seed, taps[k+1])` in the same cycle.
  - Mismatch with `k==8`: set `match_fail=1`, `pat_idx=0xF`, go to `DONE`. DM is left unwritten.
- **First match wins**: the lowest passing `k` is selected.
- **DRD**: read address 64+i and latch `d = {1'b0, rd[6:0] ^ lfsr}`.
- **DWR**
  - Write `d` to address i with `mem_wr_en=1`.
  - Step `lfsr`.
  - `i==63`: go to `DONE`; otherwise `i++`, go to `DRD`.
- **DONE**
  - `ack=1`.
  - When `req==1` is sampled: `ack=0`, go to `IDLE`.
  - `pat_idx` and the flags hold until the next start.
- **Reset**: `init` asserted in any state forces `IDLE` immediately.
  - No further writes occur; bytes already written are not restored.

## Timing
- **Reset values**: `ack=0`, `mem_wr_en=0`, `mem_addr=0`, `mem_wr_data=0`, `pat_idx=0`, `match_fail=0`, `parity_err=0`, state `IDLE`.
- **Launch**: `SEED` is entered on the first rising edge after `req` is sampled low, given `req_q=1`.
- **Search latency**: 1 (`SEED`) + number of TRY compares.
  - Best case: 1+9.
  - Worst case: 1+81, when pattern 8 is found or no pattern matches.
- **Decode**: exactly 128 cycles. Addresses go 64,0,65,1,…,127,63.
- **`ack`**: rises the cycle after the final DWR.
- **Total for pattern 0**: 1+9+128 = 138 cycles from `SEED` to `ack`.
- **Start while busy**: a `req` falling edge outside `IDLE` is ignored.
- **Release**: `req` high in `DONE` drops `ack` on the next edge. `req` held low keeps `ack` high indefinitely.

## Configuration
- **`PARITY_CHECK_EN` defined**
  - In `DRD`, if `rd[7] != ^rd[6:0]`: `d = 0x80` and `parity_err` is set (sticky until the next start).
  - Preamble compares also treat a parity-bad byte as a mismatch.
- **`PARITY_CHECK_EN` undefined**
  - Bit 7 of every encrypted byte is ignored.
  - `parity_err` is tied to 0.

## Test plan
- **Seed and pattern 0**: seed 0x01, pattern 0x60, preamble 10, message "Hi"; `DM[64]=0x21`, `DM[65]=0x22`.
  - Required: `pat_idx=0`, `DM[10]=0x48`, `DM[11]=0x69`, other bytes 0x20.
  - Required: `ack` rises 138 cycles after `SEED`.
- **Pattern 8**: pattern 0x7B, random nonzero seed, preamble 26.
  - Required: `pat_idx=8` and all 64 bytes match the bench's padded plaintext.
- **No match**: `DM[64..127]` set to a random stream that fits no pattern.
  - Required: `match_fail=1`, `pat_idx=0xF`, `ack` after ≤82 cycles, `DM[0..63]` untouched.
- **Parity error** (`PARITY_CHECK_EN`): flip bit 7 of `DM[100]`.
  - Required: `DM[36]=0x80`, `parity_err=1`, all other bytes correct.
  - Same stimulus without the macro: `DM[36]` decrypts correctly and `parity_err=0`.
- **Reset mid-run**: assert `init` during DWR of i=20.
  - Required: same-cycle return to `IDLE`, `mem_wr_en=0`, `ack=0`.
  - Required: a fresh `req` pulse then completes a correct full run.
- **Handshake**: keep `req` low after `ack`; `ack` stays 1. Then raise `req`; `ack` is 0 on the next edge, and a second falling edge starts a new run.
